// File: rtl/pipe_stage_reg_pkg.sv
// Shared constants for the inter-stage pipeline registers:
// reset/stall encodings, stall-vector indices, payload widths and NOP values.
package pipe_stage_reg_pkg;

    localparam logic RstEnable  = 1'b1;
    localparam logic RstDisable = 1'b0;
    localparam logic Stop       = 1'b1;
    localparam logic NoStop     = 1'b0;

    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EX  = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;

    localparam logic [7:0]  EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [2:0]  EXE_RES_NOP  = 3'b000;
    localparam logic [4:0]  NOPRegAddr   = 5'b00000;
    localparam logic        WriteDisable = 1'b0;
    localparam logic [31:0] ZeroWord     = 32'h0000_0000;

    // pc + inst
    localparam int IF_ID_W  = 64;
    // alusel + aluop + reg1 + reg2 + wd + wreg
    localparam int ID_EX_W  = 81;
    // wd + wreg + wdata
    localparam int EX_MEM_W = 38;
    localparam int MEM_WB_W = 38;

    localparam logic [IF_ID_W-1:0] IF_ID_NOP = {ZeroWord, ZeroWord};

    localparam logic [ID_EX_W-1:0] ID_EX_NOP =
        {EXE_RES_NOP, EXE_NOP_OP, ZeroWord, ZeroWord,
         NOPRegAddr, WriteDisable};

    localparam logic [EX_MEM_W-1:0] EX_MEM_NOP =
        {NOPRegAddr, WriteDisable, ZeroWord};

    localparam logic [MEM_WB_W-1:0] MEM_WB_NOP =
        {NOPRegAddr, WriteDisable, ZeroWord};

    typedef enum logic [1:0] {
        ACT_LOAD   = 2'd0,
        ACT_BUBBLE = 2'd1,
        ACT_HOLD   = 2'd2,
        ACT_FLUSH  = 2'd3
    } stage_act_e;

    // Flush beats stall; the illegal (up running, down stopped) pattern loads.
    function automatic stage_act_e stage_action(
        input logic flush,
        input logic up_stop,
        input logic dn_stop
    );
        if (flush)
            return ACT_FLUSH;
        else if (up_stop && !dn_stop)
            return ACT_BUBBLE;
        else if (up_stop && dn_stop)
            return ACT_HOLD;
        else
            return ACT_LOAD;
    endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
// Clear wins over a simultaneous increment.
module sat_counter
    import pipe_stage_reg_pkg::*;
#(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up to all-ones and stick there until cleared.
    always_ff @(posedge clk) begin
        if (rst == RstEnable)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// Generic pipeline boundary register with hold, bubble, flush,
// valid tracking and saturating bubble/hold/flush counters.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W  = 81,
    parameter logic [DATA_W-1:0] NOP_VAL = {DATA_W{1'b0}},
    parameter int                STALL_W = 6,
    parameter int                STAGE   = 2,
    parameter int                CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic               cnt_clr,
    input  logic [DATA_W-1:0]  in_data,
    input  logic               in_valid,
    output logic [DATA_W-1:0]  out_data,
    output logic               out_valid,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   hold_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    // Clamped so a bad STAGE still elaborates far enough to hit the check.
    localparam int NEXT = (STAGE + 1 < STALL_W) ? STAGE + 1 : STAGE;

    if ((STAGE + 1 >= STALL_W) || (STAGE < 0) || (CNT_W < 1)) begin : g_bad_cfg
        $error("pipe_stage_reg: need 0 <= STAGE < STALL_W-1 and CNT_W >= 1");
    end

    logic       up_stop;
    logic       dn_stop;
    stage_act_e act;

    assign up_stop = (stall[STAGE] == Stop);
    assign dn_stop = (stall[NEXT] == Stop);
    assign act     = stage_action(flush, up_stop, dn_stop);

    // Slot update: reset, flush, bubble, hold or load in priority order.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            out_data  <= NOP_VAL;
            out_valid <= 1'b0;
        end else begin
            unique case (act)
                ACT_FLUSH, ACT_BUBBLE: begin
                    out_data  <= NOP_VAL;
                    out_valid <= 1'b0;
                end
                ACT_HOLD: begin
                    out_data  <= out_data;
                    out_valid <= out_valid;
                end
                ACT_LOAD: begin
                    out_data  <= in_valid ? in_data : NOP_VAL;
                    out_valid <= in_valid;
                end
            endcase
            // Stall bits are kept monotonic by the controller.
            assert (!(!up_stop && dn_stop))
            else $warning("pipe_stage_reg: non-monotonic stall %b", stall);
        end
    end

    sat_counter #(.W(CNT_W)) u_bubble_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (act == ACT_BUBBLE),
        .cnt (bubble_cnt)
    );

    sat_counter #(.W(CNT_W)) u_hold_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (act == ACT_HOLD),
        .cnt (hold_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .inc (act == ACT_FLUSH),
        .cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a default-width instance and a
// CNT_W=2 instance share stimulus; a monitor checks each registered result.
module tb_pipe_stage_reg;

    localparam int DW = 81;

    logic          clk;
    logic          rst;
    logic [5:0]    stall;
    logic          flush;
    logic          cnt_clr;
    logic [DW-1:0] in_data;
    logic          in_valid;

    logic [DW-1:0] out_data;
    logic          out_valid;
    logic [15:0]   bubble_cnt;
    logic [15:0]   hold_cnt;
    logic [15:0]   flush_cnt;

    logic [DW-1:0] s_data;
    logic          s_valid;
    logic [1:0]    s_bubble;
    logic [1:0]    s_hold;
    logic [1:0]    s_flush;

    int checks = 0;
    int errors = 0;

    pipe_stage_reg dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .bubble_cnt (bubble_cnt),
        .hold_cnt   (hold_cnt),
        .flush_cnt  (flush_cnt)
    );

    pipe_stage_reg #(.CNT_W(2)) dut_small (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .out_data   (s_data),
        .out_valid  (s_valid),
        .bubble_cnt (s_bubble),
        .hold_cnt   (s_hold),
        .flush_cnt  (s_flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string         name;
        logic [DW-1:0] d;
        logic          v;
        int            b;
        int            h;
        int            f;
        int            sh;
    } exp_t;

    exp_t sb[$];

    localparam logic [DW-1:0] X1  = 81'h1_2345_6789_ABCD;
    localparam logic [DW-1:0] A   = 81'h0_AAAA_0000_1111_2222;
    localparam logic [DW-1:0] B   = 81'h1_BBBB_3333_4444_5555;
    localparam logic [DW-1:0] C   = 81'h0_CCCC_6666_7777_8888;
    localparam logic [DW-1:0] D   = 81'h1_DDDD_9999_0000_1234;
    localparam logic [DW-1:0] NOP = '0;
    localparam logic [DW-1:0] ONES = {DW{1'b1}};

    localparam logic [5:0] RUN  = 6'b000000;
    localparam logic [5:0] HOLD = 6'b001111;
    localparam logic [5:0] BUBL = 6'b000111;
    localparam logic [5:0] ILL  = 6'b001000;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every registered result is compared one half-cycle later.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk({e.name, ".data"}, out_data, e.d);
            chk({e.name, ".valid"}, DW'(out_valid), DW'(e.v));
            chk({e.name, ".bubble"}, DW'(bubble_cnt), DW'(e.b));
            chk({e.name, ".hold"}, DW'(hold_cnt), DW'(e.h));
            chk({e.name, ".flush"}, DW'(flush_cnt), DW'(e.f));
            if (e.sh >= 0)
                chk({e.name, ".s_hold"}, DW'(s_hold), DW'(e.sh));
        end
    end

    task automatic step(
        input string         nm,
        input logic          r,
        input logic [5:0]    st,
        input logic          fl,
        input logic          clr,
        input logic [DW-1:0] din,
        input logic          vin,
        input logic [DW-1:0] ed,
        input logic          ev,
        input int            eb,
        input int            eh,
        input int            ef,
        input int            esh
    );
        exp_t e;
        @(negedge clk);
        rst      = r;
        stall    = st;
        flush    = fl;
        cnt_clr  = clr;
        in_data  = din;
        in_valid = vin;
        @(posedge clk);
        e.name = nm;
        e.d    = ed;
        e.v    = ev;
        e.b    = eb;
        e.h    = eh;
        e.f    = ef;
        e.sh   = esh;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        step("rst", 1, RUN, 0, 0, NOP, 0, NOP, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: scoreboard not drained");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        stall    = RUN;
        flush    = 1'b0;
        cnt_clr  = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;

        // Reset then load
        step("t1_rst", 1, RUN, 0, 0, X1, 1, NOP, 0, 0, 0, 0, 0);
        step("t1_load", 0, RUN, 0, 0, X1, 1, X1, 1, 0, 0, 0, 0);

        // Hold for 3 cycles with changing input
        do_reset();
        step("t2_load", 0, RUN, 0, 0, A, 1, A, 1, 0, 0, 0, 0);
        step("t2_h1", 0, HOLD, 0, 0, B, 1, A, 1, 0, 1, 0, 1);
        step("t2_h2", 0, HOLD, 0, 0, C, 1, A, 1, 0, 2, 0, 2);
        step("t2_h3", 0, HOLD, 0, 0, D, 1, A, 1, 0, 3, 0, 3);

        // Bubble twice then resume
        do_reset();
        step("t3_load", 0, RUN, 0, 0, A, 1, A, 1, 0, 0, 0, 0);
        step("t3_b1", 0, BUBL, 0, 0, C, 1, NOP, 0, 1, 0, 0, 0);
        step("t3_b2", 0, BUBL, 0, 0, C, 1, NOP, 0, 2, 0, 0, 0);
        step("t3_go", 0, RUN, 0, 0, B, 1, B, 1, 2, 0, 0, 0);

        // Flush beats hold; hold count untouched
        do_reset();
        step("t4_load", 0, RUN, 0, 0, A, 1, A, 1, 0, 0, 0, 0);
        step("t4_hold", 0, HOLD, 0, 0, B, 1, A, 1, 0, 1, 0, 1);
        step("t4_flush", 0, HOLD, 1, 0, B, 1, NOP, 0, 0, 1, 1, 1);

        // Saturation on the 2-bit instance, then clear with a hold
        do_reset();
        step("t5_load", 0, RUN, 0, 0, A, 1, A, 1, 0, 0, 0, 0);
        step("t5_h1", 0, HOLD, 0, 0, B, 1, A, 1, 0, 1, 0, 1);
        step("t5_h2", 0, HOLD, 0, 0, B, 1, A, 1, 0, 2, 0, 2);
        step("t5_h3", 0, HOLD, 0, 0, B, 1, A, 1, 0, 3, 0, 3);
        step("t5_h4", 0, HOLD, 0, 0, B, 1, A, 1, 0, 4, 0, 3);
        step("t5_h5", 0, HOLD, 0, 0, B, 1, A, 1, 0, 5, 0, 3);
        step("t5_clr", 0, HOLD, 0, 1, B, 1, A, 1, 0, 0, 0, 0);
        step("t5_h6", 0, HOLD, 0, 0, B, 1, A, 1, 0, 1, 0, 1);

        // Flush together with counter clear
        step("t5_flclr", 0, RUN, 1, 1, B, 1, NOP, 0, 0, 0, 0, 0);

        // Reset during stall and flush wins, then normal load
        step("t5_rst", 1, HOLD, 1, 0, B, 1, NOP, 0, 0, 0, 0, 0);
        step("t5_resume", 0, RUN, 0, 0, C, 1, C, 1, 0, 0, 0, 0);

        // Invalid input canonicalised, illegal stall loads
        do_reset();
        step("t6_inv", 0, RUN, 0, 0, ONES, 0, NOP, 0, 0, 0, 0, 0);
        step("t6_ill", 0, ILL, 0, 0, D, 1, D, 1, 0, 0, 0, 0);
        step("t6_run", 0, RUN, 0, 0, A, 0, NOP, 0, 0, 0, 0, 0);

        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
